// File: rtl/axi_burst_ram.sv
// ---------------------------------------------------------------------------
// axi_burst_ram
//   AXI4 slave backed by a byte-writable word memory. One transaction is in
//   flight at a time: an address handshake moves the FSM out of IDLE, the
//   data beats are streamed, and the FSM returns to IDLE after the last read
//   beat or the write response handshake. FIXED, INCR and WRAP bursts are
//   supported; illegal bursts return SLVERR and beats outside the memory
//   return DECERR.
//
// Ports
//   pll_core_cpuclk   clock
//   pad_cpu_rst_b     asynchronous active-low reset
//   ar*               read address channel (arready is combinational in IDLE)
//   r*                read data channel (registered, 1-cycle memory latency)
//   aw*               write address channel (awready is combinational in IDLE)
//   w*                write data channel (wready registered, high in WRITE)
//   b*                write response channel (registered)
// ---------------------------------------------------------------------------
module axi_burst_ram #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 40,
    parameter int ID_W      = 8,
    parameter int DEPTH     = 65536,
    parameter     INIT_FILE = ""
) (
    input  logic                  pll_core_cpuclk,
    input  logic                  pad_cpu_rst_b,
    // read address channel
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [ID_W-1:0]       arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    // read data channel
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [ID_W-1:0]       rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    // write address channel
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [ID_W-1:0]       awid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    // write data channel
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    // write response channel
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WRITE_RESP
    } state_t;

    // Illegal burst type, beat wider than the bus, or WRAP of a length AXI forbids.
    function automatic logic txn_err(input logic [1:0] burst,
                                     input logic [2:0] size,
                                     input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (int'(size) > OFFS) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Response severity order is DECERR > SLVERR > OKAY, which matches the encoding.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                terr_q;
    logic [7:0]          cnt_q;
    logic                rd_done_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;
    logic [ID_W-1:0]     rid_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [ID_W-1:0]     bid_q;

    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   incr_bytes;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   word_idx;
    logic [IDX_W-1:0]    mem_idx;
    logic [1:0]          beat_resp;
    logic [1:0]          wbeat_resp;
    logic                beat_last;
    logic                ar_hs;
    logic                aw_hs;
    logic                rd_issue;
    logic                w_hs;
    logic                mem_we;

    // Address channels: a pending read always wins the arbitration in IDLE.
    assign arready = (state_q == IDLE) && arvalid;
    assign awready = (state_q == IDLE) && !arvalid;
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;

    // Next beat address. WRAP keeps the upper bits of the aligned block and
    // lets only the offset inside the (len+1)*2^size block advance.
    assign incr_bytes = ADDR_W'(1) << size_q;
    assign wrap_mask  = (ADDR_W'({1'b0, len_q} + 9'd1) << size_q) - ADDR_W'(1);

    always_comb begin
        addr_d = addr_q + incr_bytes;
        case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~wrap_mask) | ((addr_q + incr_bytes) & wrap_mask);
            default: addr_d = addr_q + incr_bytes;
        endcase
    end

    assign word_idx  = addr_q >> OFFS;
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign beat_resp = terr_q                       ? RESP_SLVERR :
                       (word_idx >= ADDR_W'(DEPTH)) ? RESP_DECERR : RESP_OKAY;
    assign beat_last = (cnt_q == len_q);

    // Issue a read whenever the output register is empty or being drained.
    assign rd_issue  = (state_q == READ) && !rd_done_q && (!rvalid_q || rready);
    assign w_hs      = (state_q == WRITE) && wvalid && wready_q;
    // The final beat is defined by the beat count; a disagreeing wlast is an error.
    assign wbeat_resp = worse(beat_resp, (wlast != beat_last) ? RESP_SLVERR : RESP_OKAY);
    assign mem_we    = w_hs && (beat_resp == RESP_OKAY);

    always_ff @(posedge pll_core_cpuclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            terr_q    <= 1'b0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    rd_done_q <= 1'b0;
                    if (ar_hs) begin
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        size_q  <= arsize;
                        burst_q <= arburst;
                        terr_q  <= txn_err(arburst, arsize, arlen);
                        rid_q   <= arid;
                        state_q <= READ;
                    end else if (aw_hs) begin
                        addr_q   <= awaddr;
                        len_q    <= awlen;
                        size_q   <= awsize;
                        burst_q  <= awburst;
                        terr_q   <= txn_err(awburst, awsize, awlen);
                        bid_q    <= awid;
                        bresp_q  <= RESP_OKAY;
                        wready_q <= 1'b1;
                        state_q  <= WRITE;
                    end
                end

                READ: begin
                    if (rd_issue) begin
                        rvalid_q  <= 1'b1;
                        rdata_q   <= (beat_resp == RESP_OKAY) ? mem[mem_idx] : '0;
                        rresp_q   <= beat_resp;
                        rlast_q   <= beat_last;
                        // Separate done flag: an 8-bit count cannot express 256 issued beats.
                        rd_done_q <= beat_last;
                        cnt_q     <= cnt_q + 8'd1;
                        addr_q    <= addr_d;
                    end else if (rvalid_q && rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end

                WRITE: begin
                    if (w_hs) begin
                        cnt_q   <= cnt_q + 8'd1;
                        addr_q  <= addr_d;
                        bresp_q <= worse(bresp_q, wbeat_resp);
                        if (beat_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            state_q  <= WRITE_RESP;
                        end
                    end
                end

                WRITE_RESP: begin
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rid    = rid_q;
    assign wready = wready_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign bid    = bid_q;

endmodule

// File: tb/tb_axi_burst_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_ram
//   Directed bench for axi_burst_ram (DATA_W=128, DEPTH=1024). A reference
//   memory is kept in the bench; read/write expectations are queued when a
//   transaction is set up and compared as the DUT returns beats/responses.
// ---------------------------------------------------------------------------
module tb_axi_burst_ram;

    localparam int DW    = 128;
    localparam int AW    = 40;
    localparam int IW    = 8;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            arvalid = 1'b0, arready;
    logic [AW-1:0]   araddr = '0;
    logic [IW-1:0]   arid = '0;
    logic [7:0]      arlen = '0;
    logic [2:0]      arsize = '0;
    logic [1:0]      arburst = '0;
    logic            rvalid, rready = 1'b0;
    logic [DW-1:0]   rdata;
    logic [IW-1:0]   rid;
    logic [1:0]      rresp;
    logic            rlast;
    logic            awvalid = 1'b0, awready;
    logic [AW-1:0]   awaddr = '0;
    logic [IW-1:0]   awid = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = '0;
    logic [1:0]      awburst = '0;
    logic            wvalid = 1'b0, wready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wlast = 1'b0;
    logic            bvalid, bready = 1'b0;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;

    always #5 clk = ~clk;

    axi_burst_ram #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH(DEPTH), .INIT_FILE("")
    ) dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    typedef struct { logic [DW-1:0] d; logic [1:0] resp; logic last; logic [7:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [7:0] id; } bexp_t;

    rexp_t         rq[$];
    bexp_t         bq[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wd [256];
    logic [15:0]   ws [256];
    int            errors = 0;
    int            checks = 0;
    int            f, l;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_wr(input int idx, input logic [DW-1:0] d, input logic [15:0] s);
        for (int b = 0; b < 16; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic exp_r(input int idx, input logic [7:0] id, input logic last);
        rq.push_back('{model[idx], 2'b00, last, id});
    endtask

    task automatic exp_re(input logic [1:0] resp, input logic [7:0] id, input logic last);
        rq.push_back('{'0, resp, last, id});
    endtask

    task automatic send_addr(input bit rd, input logic [AW-1:0] a, input logic [7:0] id,
                             input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        int t;
        @(negedge clk);
        if (rd) begin
            araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        end else begin
            awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        end
        t = 0;
        #1;
        while (!(rd ? arready : awready) && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk(rd ? "ar_accept" : "aw_accept", rd ? arready : awready, 1);
        @(posedge clk); #1;
        if (rd) arvalid = 1'b0; else awvalid = 1'b0;
    endtask

    // mode 0: rready held high, mode 1: rready toggles. abort_at >= 0 asserts
    // reset when that beat index is presented.
    task automatic collect_read(input int mode, input int abort_at, output int first_n, output int last_n);
        int n, popped;
        n = 0; popped = 0; first_n = -1; last_n = -1;
        while (rq.size() > 0 && n < 1000) begin
            @(negedge clk); n++;
            rready = (mode == 1) ? n[0] : 1'b1;
            #1;
            if (awvalid) chk("aw_blocked_in_read", awready, 0);
            if (rvalid) begin
                if (first_n < 0) first_n = n;
                if (abort_at == popped) begin
                    rst_b = 1'b0;
                    #1;
                    chk("rst_rvalid", rvalid, 0);
                    chk("rst_rdata", rdata, 0);
                    chk("rst_rlast", rlast, 0);
                    chk("rst_rresp", rresp, 0);
                    chk("rst_rid", rid, 0);
                    rq.delete();
                    break;
                end
                chk("rdata", rdata, rq[0].d);
                chk("rresp", rresp, rq[0].resp);
                chk("rlast", rlast, rq[0].last);
                chk("rid", rid, rq[0].id);
                if (rready) begin
                    void'(rq.pop_front());
                    popped++;
                    last_n = n;
                end
            end
        end
        if (rq.size() > 0) begin
            chk("read_timeout", rq.size(), 0);
            rq.delete();
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    // wl_mode 0: wlast on the final beat, 1: wlast never asserted.
    task automatic write_data(input int len, input int wl_mode);
        int t;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast = (wl_mode == 0) ? (i == len) : 1'b0;
            t = 0;
            #1;
            while (!wready && t < 200) begin
                @(negedge clk); #1; t++;
            end
            if (!wready) begin
                chk("w_accept", wready, 1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        int t;
        @(negedge clk);
        bready = 1'b1;
        t = 0;
        #1;
        while (!bvalid && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk("b_seen", bvalid, 1);
        if (bvalid && bq.size() > 0) begin
            chk("bresp", bresp, bq[0].resp);
            chk("bid", bid, bq[0].id);
            void'(bq.pop_front());
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] id, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, input int wl_mode);
        send_addr(0, a, id, len, sz, bu);
        write_data(int'(len), wl_mode);
        wait_b();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] id, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, input int mode);
        int fn, ln;
        send_addr(1, a, id, len, sz, bu);
        collect_read(mode, -1, fn, ln);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid0", rvalid, 0);
        chk("rst_bvalid0", bvalid, 0);
        chk("rst_wready0", wready, 0);
        chk("rst_rlast0", rlast, 0);
        chk("rst_rresp0", rresp, 0);
        chk("rst_bresp0", bresp, 0);
        chk("rst_rid0", rid, 0);
        chk("rst_bid0", bid, 0);
        chk("rst_rdata0", rdata, 0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("idle_arready", arready, 0);
        chk("idle_awready", awready, 1);

        // 256-beat INCR preload of words 0..255, word 0 all ones, then read back
        for (int i = 0; i < 256; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = 16'hFFFF;
        end
        wd[0] = '1;
        for (int i = 0; i < 256; i++) model_wr(i, wd[i], ws[i]);
        bq.push_back('{2'b00, 8'h11});
        wr(40'h0, 8'h11, 8'd255, 3'd4, 2'b01, 0);
        for (int i = 0; i < 256; i++) exp_r(i, 8'h22, i == 255);
        rd(40'h0, 8'h22, 8'd255, 3'd4, 2'b01, 0);

        // INCR len=3 at 0x100: words 0x10..0x13, latency and back-to-back
        for (int i = 0; i < 4; i++) exp_r(16 + i, 8'h31, i == 3);
        send_addr(1, 40'h100, 8'h31, 8'd3, 3'd4, 2'b01);
        collect_read(0, -1, f, l);
        chk("first_rvalid_lat", f, 2);
        chk("beats_consecutive", l - f, 3);

        // WRAP write len=3 at 0x130: A,B,C,D land in words 0x13,0x10,0x11,0x12
        wd[0] = {4{32'hAAAA_0001}}; wd[1] = {4{32'hBBBB_0002}};
        wd[2] = {4{32'hCCCC_0003}}; wd[3] = {4{32'hDDDD_0004}};
        for (int i = 0; i < 4; i++) ws[i] = 16'hFFFF;
        model_wr('h13, wd[0], 16'hFFFF); model_wr('h10, wd[1], 16'hFFFF);
        model_wr('h11, wd[2], 16'hFFFF); model_wr('h12, wd[3], 16'hFFFF);
        bq.push_back('{2'b00, 8'h32});
        wr(40'h130, 8'h32, 8'd3, 3'd4, 2'b10, 0);
        rq.push_back('{{4{32'hBBBB_0002}}, 2'b00, 1'b0, 8'h33});
        rq.push_back('{{4{32'hCCCC_0003}}, 2'b00, 1'b0, 8'h33});
        rq.push_back('{{4{32'hDDDD_0004}}, 2'b00, 1'b0, 8'h33});
        rq.push_back('{{4{32'hAAAA_0001}}, 2'b00, 1'b1, 8'h33});
        rd(40'h100, 8'h33, 8'd3, 3'd4, 2'b01, 0);
        exp_r('h13, 8'h34, 0); exp_r('h10, 8'h34, 0); exp_r('h11, 8'h34, 0); exp_r('h12, 8'h34, 1);
        rd(40'h130, 8'h34, 8'd3, 3'd4, 2'b10, 0);

        // partial strobe on an all-ones word: only the low 8 bytes are cleared
        wd[0] = '0; ws[0] = 16'h00FF;
        model_wr(0, wd[0], ws[0]);
        bq.push_back('{2'b00, 8'h35});
        wr(40'h0, 8'h35, 8'd0, 3'd4, 2'b01, 0);
        rq.push_back('{{64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 2'b00, 1'b1, 8'h36});
        rd(40'h0, 8'h36, 8'd0, 3'd4, 2'b01, 0);

        // last word then past the end: OKAY then DECERR with zero data
        wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = 16'hFFFF;
        model_wr(DEPTH - 1, wd[0], ws[0]);
        bq.push_back('{2'b00, 8'h41});
        wr(40'h3FF0, 8'h41, 8'd0, 3'd4, 2'b01, 0);
        exp_r(DEPTH - 1, 8'h42, 0);
        exp_re(2'b11, 8'h42, 1);
        rd(40'h3FF0, 8'h42, 8'd1, 3'd4, 2'b01, 0);
        bq.push_back('{2'b11, 8'h43});
        wr(40'h4000, 8'h43, 8'd0, 3'd4, 2'b01, 0);

        // simultaneous AR/AW: read first with toggling rready, write afterwards
        exp_r('h10, 8'h51, 0); exp_r('h11, 8'h51, 1);
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        wd[1] = {$urandom, $urandom, $urandom, $urandom};
        ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
        model_wr('h20, wd[0], ws[0]); model_wr('h21, wd[1], ws[1]);
        bq.push_back('{2'b00, 8'h52});
        @(negedge clk);
        araddr = 40'h100; arid = 8'h51; arlen = 8'd1; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        awaddr = 40'h200; awid = 8'h52; awlen = 8'd1; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk("both_arready", arready, 1);
        chk("both_awready", awready, 0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        collect_read(1, -1, f, l);
        #1;
        chk("aw_after_read", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        write_data(1, 0);
        wait_b();
        exp_r('h20, 8'h53, 0); exp_r('h21, 8'h53, 1);
        rd(40'h200, 8'h53, 8'd1, 3'd4, 2'b01, 0);

        // transaction errors
        exp_re(2'b10, 8'h61, 0); exp_re(2'b10, 8'h61, 1);
        rd(40'h100, 8'h61, 8'd1, 3'd4, 2'b11, 0);
        exp_re(2'b10, 8'h62, 1);
        rd(40'h100, 8'h62, 8'd0, 3'd5, 2'b01, 0);
        for (int i = 0; i < 3; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'hFFFF;
        end
        bq.push_back('{2'b10, 8'h63});
        wr(40'h200, 8'h63, 8'd2, 3'd4, 2'b10, 0);
        exp_r('h20, 8'h64, 1);
        rd(40'h200, 8'h64, 8'd0, 3'd4, 2'b01, 0);
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        wd[1] = {$urandom, $urandom, $urandom, $urandom};
        model_wr('h30, wd[0], 16'hFFFF); model_wr('h31, wd[1], 16'hFFFF);
        bq.push_back('{2'b10, 8'h65});
        wr(40'h300, 8'h65, 8'd1, 3'd4, 2'b01, 1);
        exp_r('h30, 8'h66, 0); exp_r('h31, 8'h66, 1);
        rd(40'h300, 8'h66, 8'd1, 3'd4, 2'b01, 0);

        // FIXED read repeats the same word
        exp_r('h10, 8'h67, 0); exp_r('h10, 8'h67, 0); exp_r('h10, 8'h67, 1);
        rd(40'h100, 8'h67, 8'd2, 3'd4, 2'b00, 0);

        // narrow 8-byte INCR write: two beats per word on alternating lanes
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = i[0] ? 16'hFF00 : 16'h00FF;
        end
        model_wr('h40, wd[0], 16'h00FF); model_wr('h40, wd[1], 16'hFF00);
        model_wr('h41, wd[2], 16'h00FF); model_wr('h41, wd[3], 16'hFF00);
        bq.push_back('{2'b00, 8'h68});
        wr(40'h400, 8'h68, 8'd3, 3'd3, 2'b01, 0);
        exp_r('h40, 8'h69, 0); exp_r('h41, 8'h69, 1);
        rd(40'h400, 8'h69, 8'd1, 3'd4, 2'b01, 0);

        // reset during beat 2 of an 8-beat read, then a clean read
        for (int i = 0; i < 8; i++) exp_r(i, 8'h71, i == 7);
        send_addr(1, 40'h0, 8'h71, 8'd7, 3'd4, 2'b01);
        collect_read(0, 2, f, l);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("post_rst_arready", arready, 0);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 0);
        exp_r(0, 8'h72, 0); exp_r(1, 8'h72, 1);
        rd(40'h0, 8'h72, 8'd1, 3'd4, 2'b01, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
